// File: rtl/wb_stage.sv
// Writeback stage: merges execute and MDU results into the register file write port,
// tracks pending MDU destinations for decode hazards, and bypasses the in-flight write.
module wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_wd,
    input  logic            mdu_issue,
    input  logic [4:0]      mdu_issue_rd,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wd,
    output logic            mdu_ready,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_we,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            hazard_stall,
    output logic            rf_w_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wd
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic            ex_req;
    logic            mdu_accept;
    logic            mdu_write;
    logic            refused;
    logic            starve;
    logic [31:0]     busy;
    logic [31:0]     busy_set;
    logic [31:0]     busy_clr;
    logic [31:0]     busy_next;
    logic [CW-1:0]   starve_cnt;

    assign ex_req     = ex_valid & ex_we & (ex_rd != 5'd0);
    assign mdu_ready  = ~ex_req;
    assign mdu_accept = mdu_valid & mdu_ready;
    assign mdu_write  = mdu_accept & (mdu_rd != 5'd0);
    assign refused    = mdu_valid & ~mdu_ready;
    assign starve     = (starve_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w_en <= 1'b0;
            rf_rd   <= '0;
            rf_wd   <= '0;
        end else if (ex_req) begin
            rf_w_en <= 1'b1;
            rf_rd   <= ex_rd;
            rf_wd   <= ex_wd;
        end else if (mdu_write) begin
            rf_w_en <= 1'b1;
            rf_rd   <= mdu_rd;
            rf_wd   <= mdu_wd;
        end else begin
            rf_w_en <= 1'b0;
        end
    end

    // Set is OR-ed after the clear so a same-cycle issue of the same register wins.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (mdu_issue) busy_set[mdu_issue_rd] = 1'b1;
        if (mdu_accept) busy_clr[mdu_rd] = 1'b1;
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (refused) begin
            if (!starve) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_comb begin
        hazard_stall = starve |
                       (id_valid & (busy[id_rs1] | busy[id_rs2] | (id_we & busy[id_rd])));
        op_a = (rf_w_en && rf_rd == id_rs1 && id_rs1 != 5'd0) ? rf_wd : rf_rd1;
        op_b = (rf_w_en && rf_rd == id_rs2 && id_rs2 != 5'd0) ? rf_wd : rf_rd2;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage sitting directly upstream of the integer register file. It owns the register file's single write port.
- It merges two result sources into one registered write per cycle: the in-order execute pipeline and the iterative multiply/divide unit (MDU).
- It keeps a pending-destination scoreboard for MDU ops and raises a decode stall on RAW/WAW hazards against those ops.
- It bypasses the just-written value onto decode operand reads, because the register file reads combinationally and writes only on the clock edge.

Parameters:
- XLEN, 32, data width of results and operands.
- STARVE_LIMIT, 4, number of consecutive cycles an MDU result may be refused before a forced pipeline stall.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  execute result present this cycle. No backpressure: always consumed.
- ex_we  in  1  execute result writes a register.
- ex_rd  in  5  execute destination register.
- ex_wd  in  XLEN  execute result data.
- mdu_issue  in  1  decode is dispatching an MDU op this cycle.
- mdu_issue_rd  in  5  destination register of the dispatched MDU op.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_wd  in  XLEN  MDU result data.
- mdu_ready  out  1  MDU result accepted this cycle.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  5 each  decode source registers.
- id_we  in  1  decode instruction writes a register.
- id_rd  in  5  decode destination register.
- rf_rd1, rf_rd2  in  XLEN each  raw register file read data.
- op_a, op_b  out  XLEN each  bypassed operands delivered to decode.
- hazard_stall  out  1  decode must hold and insert a bubble.
- rf_w_en  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.

Behaviour:
- Reset (rst_n low, asynchronous): rf_w_en=0, rf_rd=0, rf_wd=0, all busy bits=0, starve counter=0. Combinational outputs then follow their equations.
- Write requests:
  - ex_req = ex_valid & ex_we & (ex_rd!=0).
  - mdu_ready = ~ex_req, combinational. The execute source always has priority.
- Output register, updated every posedge:
  - If ex_req: rf_w_en=1, rf_rd=ex_rd, rf_wd=ex_wd.
  - Else if mdu_valid & (mdu_rd!=0): rf_w_en=1, rf_rd=mdu_rd, rf_wd=mdu_wd.
  - Else rf_w_en=0, and rf_rd/rf_wd hold their previous values.
- Latency: exactly 1 cycle from an accepted source to rf_w_en. The register file commits on the following edge.
- MDU accept (mdu_valid & mdu_ready) with mdu_rd=0: handshake completes, no write, no scoreboard change.
- Scoreboard busy[31:1]:
  - Set busy[mdu_issue_rd] on mdu_issue when mdu_issue_rd!=0.
  - Clear busy[mdu_rd] on MDU accept.
  - Set and clear of the same index in the same cycle: set wins.
  - busy[0] is constant 0.
- Starve counter:
  - Increments while mdu_valid & ~mdu_ready, saturating at STARVE_LIMIT.
  - Resets to 0 on any cycle without a refused MDU result.
  - starve = (counter == STARVE_LIMIT).
- hazard_stall = starve | (id_valid & (busy[id_rs1] | busy[id_rs2] | (id_we & busy[id_rd]))), combinational. While stalled, upstream issues bubbles (ex_valid=0), so the MDU is accepted within the pipeline drain time.
- Bypass: op_a = (rf_w_en & rf_rd==id_rs1 & id_rs1!=0) ? rf_wd : rf_rd1. op_b is the same with id_rs2/rf_rd2. This covers the cycle in which the write is pending at the register file port.
- Mid-operation reset clears the scoreboard. An MDU result arriving after reset is still written, but no stall is tracked for it.
- The MDU has one outstanding op; a second issue before the first completes is out of contract.

Test Plan:
- Reset then ex_valid=1, ex_we=1, ex_rd=5, ex_wd=0xDEADBEEF -> next cycle rf_w_en=1, rf_rd=5, rf_wd=0xDEADBEEF; cycle after, rf_w_en=0.
- ex_req and mdu_valid (rd=7, wd=0x12) in the same cycle -> mdu_ready=0, ex result written. Next cycle with ex idle -> mdu_ready=1, rf_rd=7, rf_wd=0x12.
- mdu_issue_rd=9, then id_valid with id_rs2=9 -> hazard_stall=1 until the MDU result for x9 is accepted; it drops in the accept cycle+1.
- ex_req held high for 4 cycles while mdu_valid=1 -> starve counter reaches 4, hazard_stall=1; ex_valid dropped -> MDU accepted, counter returns to 0.
- rf_w_en=1, rf_rd=3, rf_wd=0xA5A5A5A5 with id_rs1=3, rf_rd1=0 -> op_a=0xA5A5A5A5. Same with id_rs1=0 -> op_a=rf_rd1.
- ex_rd=0 write and mdu_rd=0 result -> no rf_w_en, no busy change; assert rst_n low mid-stall -> busy cleared, hazard_stall=0 immediately.
